// File: rtl/thread_issue_sched.sv
// Fine-grained 4-thread issue scheduler: round-robin pick among enabled, unblocked
// threads; keeps one PC per thread, applies redirects and fixed-length hazard blocks.
module thread_issue_sched #(
    parameter int PC_WIDTH         = 9,
    parameter int THREAD_PC_STRIDE = 128,
    parameter int BLOCK_CYCLES     = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [3:0]          thread_en,
    input  logic                stall,
    input  logic                block_req,
    input  logic [1:0]          block_tid,
    input  logic                redirect_valid,
    input  logic [1:0]          redirect_tid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                issue_valid,
    output logic [1:0]          issue_tid,
    output logic [PC_WIDTH-1:0] issue_pc,
    output logic [3:0]          blocked_mask
);

    // issue_valid qualifies issue_tid/issue_pc; there is no ready, a stall freezes all three.
    logic [PC_WIDTH-1:0] pc [4];
    logic [2:0]          blk_cnt [4];
    logic [1:0]          last_tid;
    logic [3:0]          eligible;
    logic [1:0]          sel;
    logic                any_elig;
    logic                issue_go;

    always_comb begin
        eligible     = '0;
        blocked_mask = '0;
        for (int t = 0; t < 4; t++) begin
            eligible[t]     = thread_en[t] & (blk_cnt[t] == 3'd0);
            blocked_mask[t] = (blk_cnt[t] != 3'd0);
        end
    end

    // Search order last_tid+1 .. last_tid+4; the 2-bit index wraps naturally.
    always_comb begin
        sel      = last_tid;
        any_elig = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!any_elig && eligible[last_tid + 2'(i)]) begin
                sel      = last_tid + 2'(i);
                any_elig = 1'b1;
            end
        end
    end

    assign issue_go = !stall && any_elig;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            issue_valid <= 1'b0;
            issue_tid   <= 2'd0;
            issue_pc    <= '0;
            last_tid    <= 2'd3;
            for (int t = 0; t < 4; t++) begin
                pc[t]      <= PC_WIDTH'(t * THREAD_PC_STRIDE);
                blk_cnt[t] <= 3'd0;
            end
        end else begin
            if (!stall) begin
                issue_valid <= any_elig;
                if (any_elig) begin
                    issue_tid <= sel;
                    issue_pc  <= pc[sel];
                    last_tid  <= sel;
                end
            end
            // A redirect wins over both the PC increment and a block request.
            for (int t = 0; t < 4; t++) begin
                if (redirect_valid && redirect_tid == 2'(t)) begin
                    pc[t]      <= redirect_pc;
                    blk_cnt[t] <= 3'd0;
                end else begin
                    if (issue_go && sel == 2'(t))
                        pc[t] <= pc[t] + PC_WIDTH'(1);
                    if (block_req && block_tid == 2'(t))
                        blk_cnt[t] <= 3'(BLOCK_CYCLES);
                    else if (blk_cnt[t] != 3'd0)
                        blk_cnt[t] <= blk_cnt[t] - 3'd1;
                end
            end
        end
    end

endmodule

// File: doc/thread_issue_sched.md
Name: thread_issue_sched

Overview:
- Fine-grained 4-thread issue scheduler at the front of the 16-bit multithreaded pipeline.
- Each cycle it selects one eligible thread round-robin and emits that thread's fetch PC and 2-bit thread ID. The thread ID travels down the pipeline registers alongside the instruction.
- Holds one PC per thread, applies branch/jump redirects, and blocks a thread for a fixed number of cycles after a hazard-producing instruction (load, branch) so that no forwarding is required.

Parameters:
- PC_WIDTH, 9, width of each per-thread instruction word address.
- THREAD_PC_STRIDE, 128, reset PC of thread t is t*THREAD_PC_STRIDE (mod 2^PC_WIDTH).
- BLOCK_CYCLES, 3, cycles a thread is ineligible after block_req; legal 1..7.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- thread_en  input  4  per-thread enable; bit t=1 allows thread t to issue.
- stall  input  1  global pipeline stall; freezes issue.
- block_req  input  1  the instruction of thread block_tid needs a hazard block.
- block_tid  input  2  thread to block.
- redirect_valid  input  1  load a new PC for redirect_tid.
- redirect_tid  input  2  thread being redirected.
- redirect_pc  input  PC_WIDTH  target PC.
- issue_valid  output  1  registered; an issue slot is valid this cycle.
- issue_tid  output  2  registered; thread issued.
- issue_pc  output  PC_WIDTH  registered; PC fetched for issue_tid.
- blocked_mask  output  4  bit t=1 when thread t's block counter is non-zero.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - issue_valid=0, issue_tid=0, issue_pc=0, blocked_mask=0.
  - pc[t]=t*THREAD_PC_STRIDE; all block counters 0.
  - Round-robin pointer last_tid=3, so thread 0 wins first.
- Eligibility: eligible[t] = thread_en[t] & (blk_cnt[t]==0). Uses register values at the start of the cycle.
- Selection: first eligible thread searching last_tid+1, last_tid+2, ... modulo 4.
- Issue cycle (stall=0, at least one eligible thread), at the clock edge:
  - issue_valid<=1, issue_tid<=sel, issue_pc<=pc[sel].
  - pc[sel]<=pc[sel]+1, wrapping modulo 2^PC_WIDTH.
  - last_tid<=sel.
  - Latency: one cycle from eligibility to the registered output.
- No eligible thread (stall=0): issue_valid<=0; issue_tid, issue_pc, last_tid and PCs hold.
- stall=1:
  - All issue outputs, PCs and last_tid hold; issue_valid holds its previous value.
  - Block counters still decrement.
  - Redirects and block_req are still applied.
- Block counters:
  - block_req sets blk_cnt[block_tid]<=BLOCK_CYCLES.
  - Otherwise a non-zero counter decrements by 1 each cycle.
  - blocked_mask[t] = (blk_cnt[t]!=0), combinational from the registers.
- Redirect:
  - pc[redirect_tid]<=redirect_pc and blk_cnt[redirect_tid]<=0.
  - Overrides the +1 increment when the same thread issues in the same cycle.
  - Overrides block_req for the same thread.
- block_req and issue of the same thread in one cycle: the issue proceeds; the block takes effect from the next cycle.
- block_req and redirect for different threads in one cycle: both are applied.
- Disabling a thread mid-operation: its PC and counter are preserved and it simply stops being selected. Re-enabling resumes at the saved PC.
- Reset asserted mid-operation discards all in-flight state; no output glitch other than the immediate return to reset values.

Test Plan:
- Reset release, thread_en=4'hF, no stall → issue_tid sequence 0,1,2,3,0,1 with issue_pc 0,128,256,384,1,129; issue_valid=1 from the first edge after reset.
- thread_en=4'b0101 → issue_tid alternates 0,2,0,2; PCs 0,256,1,257. With thread_en=0, issue_valid=0 and the outputs hold.
- All enabled; block_req with block_tid=1 asserted in the cycle thread 1 issues (BLOCK_CYCLES=3):
  - blocked_mask=4'b0010 for exactly 3 cycles.
  - Thread 1 is skipped (sequence 2,3,0), then re-issues at PC 129.
- redirect_valid with redirect_tid=2, redirect_pc=9'h040, same cycle thread 2 issues at 256 → the next thread 2 issue has issue_pc=0x040 (not 257). A redirect to a blocked thread clears its blocked_mask bit the next cycle.
- stall=1 for 4 cycles mid-stream:
  - Outputs frozen, PCs and pointer unchanged.
  - A block counter set just before the stall reaches 0 during it.
  - After the stall releases, issue resumes with the next round-robin thread.
- PC wrap: redirect thread 3 to 9'h1FF → it issues 0x1FF, then 0x000. Assert RST mid-stream → outputs are 0 immediately; after release the sequence restarts at thread 0, PC 0.
